// File: rtl/lpf_decim.sv
// Integrate-and-dump decimator behind the IIR LPF: averages each frame of DECIM
// valid samples and queues the rounded means in a small first-word-fall-through FIFO.
module lpf_decim #(
  parameter int in_width   = 15,
  parameter int LOG2_DECIM = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                I_clk,
  input  logic                I_reset_n,
  input  logic                I_valid,
  input  logic [in_width:0]   I_data,
  output logic                O_valid,
  input  logic                O_ready,
  output logic [in_width:0]   O_data,
  output logic                O_overrun,
  output logic [FIFO_AW:0]    O_level
);

  localparam int ACC_W = in_width + 1 + LOG2_DECIM;
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(2 ** (LOG2_DECIM - 1));
  localparam logic signed [SUM_W-1:0] RES_MAX = SUM_W'((2 ** in_width) - 1);
  localparam logic signed [SUM_W-1:0] RES_MIN = ~RES_MAX;
  localparam logic [FIFO_AW:0]        FULL_LEVEL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]        LEVEL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]      PTR_ONE    = FIFO_AW'(1);
  localparam logic [LOG2_DECIM-1:0]   PHASE_ONE  = LOG2_DECIM'(1);

  logic [LOG2_DECIM-1:0]    phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SUM_W-1:0]  sum_rnd;
  logic signed [SUM_W-1:0]  shifted;
  logic [in_width:0]        res;
  logic                     dump;
  logic                     pop;
  logic                     full;
  logic                     write_en;
  logic [FIFO_AW-1:0]       rd_ptr;
  logic [FIFO_AW-1:0]       wr_ptr;
  logic [FIFO_AW-1:0]       rd_next;
  logic [FIFO_AW:0]         level;
  logic [in_width:0]        mem [FIFO_DEPTH];

  // Rounded mean of the completing frame; the clamp is only a guard.
  always_comb begin
    sum_rnd = SUM_W'(acc) + SUM_W'($signed(I_data)) + ROUND;
    shifted = sum_rnd >>> LOG2_DECIM;
    res     = shifted[in_width:0];
    if (shifted > RES_MAX)
      res = RES_MAX[in_width:0];
    else if (shifted < RES_MIN)
      res = RES_MIN[in_width:0];
  end

  assign dump     = I_valid && (phase == '1);
  assign full     = (level == FULL_LEVEL);
  assign pop      = O_valid && O_ready;
  assign write_en = dump && (!full || pop);
  assign rd_next  = rd_ptr + PTR_ONE;
  assign O_valid  = (level != '0);
  assign O_level  = level;

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      phase <= '0;
      acc   <= '0;
    end else if (I_valid) begin
      phase <= phase + PHASE_ONE;
      if (phase == '0)
        acc <= ACC_W'($signed(I_data));
      else
        acc <= acc + ACC_W'($signed(I_data));
    end
  end

  always_ff @(posedge I_clk) begin
    if (write_en)
      mem[wr_ptr] <= res;
  end

  // O_data is a register so it can keep the last head once the FIFO drains.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      O_data    <= '0;
      O_overrun <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_next;
      if (write_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (write_en && !pop)
        level <= level + LEVEL_ONE;
      else if (pop && !write_en)
        level <= level - LEVEL_ONE;
      if (dump && full && !pop)
        O_overrun <= 1'b1;
      if (pop) begin
        if (level > LEVEL_ONE)
          O_data <= mem[rd_next];
        else if (write_en)
          O_data <= res;
      end else if (write_en && level == '0) begin
        O_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_lpf_decim.sv
// Scoreboard bench for lpf_decim: frame means are queued as samples are driven
// and compared against the FIFO head every cycle.
module tb_lpf_decim;

  logic        I_clk = 1'b0;
  logic        I_reset_n;
  logic        I_valid;
  logic [15:0] I_data;
  logic        O_valid;
  logic        O_ready;
  logic [15:0] O_data;
  logic        O_overrun;
  logic [2:0]  O_level;

  int assertCount = 0;
  int failCount   = 0;

  int q[$];
  int mPhase   = 0;
  int mSum     = 0;
  int mOverrun = 0;
  int lastHead = 0;

  lpf_decim dut (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .I_valid   (I_valid),
    .I_data    (I_data),
    .O_valid   (O_valid),
    .O_ready   (O_ready),
    .O_data    (O_data),
    .O_overrun (O_overrun),
    .O_level   (O_level)
  );

  always #5 I_clk = ~I_clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, then drive new inputs.
  task automatic applyStimulus(input logic v, input int d, input logic r);
    int res;
    @(negedge I_clk);
    checkOutput("O_valid", int'(O_valid), int'(q.size() != 0));
    checkOutput("O_level", int'(O_level), q.size());
    checkOutput("O_overrun", int'(O_overrun), mOverrun);
    if (q.size() != 0)
      checkOutput("O_data_head", int'($signed(O_data)), q[0]);
    else
      checkOutput("O_data_hold", int'($signed(O_data)), lastHead);
    if (r && q.size() != 0)
      lastHead = q.pop_front();
    I_valid = v;
    I_data  = 16'(d);
    O_ready = r;
    if (v) begin
      if (mPhase == 0) mSum = d;
      else             mSum = mSum + d;
      if (mPhase == 7) begin
        res = (mSum + 4) >>> 3;
        if (res > 32767)  res = 32767;
        if (res < -32768) res = -32768;
        if (q.size() < 4) q.push_back(res);
        else              mOverrun = 1;
      end
      mPhase = (mPhase + 1) % 8;
    end
  endtask

  task automatic applyReset();
    @(negedge I_clk);
    I_reset_n = 1'b0;
    I_valid   = 1'b0;
    I_data    = '0;
    O_ready   = 1'b0;
    @(negedge I_clk);
    checkOutput("rst_O_valid", int'(O_valid), 0);
    checkOutput("rst_O_data", int'(O_data), 0);
    checkOutput("rst_O_overrun", int'(O_overrun), 0);
    checkOutput("rst_O_level", int'(O_level), 0);
    I_reset_n = 1'b1;
    q.delete();
    mPhase   = 0;
    mSum     = 0;
    mOverrun = 0;
    lastHead = 0;
  endtask

  task automatic sendFrame(input int s0, input int s1, input int s2, input int s3,
                           input int s4, input int s5, input int s6, input int s7,
                           input logic r);
    int vals[8];
    vals = '{s0, s1, s2, s3, s4, s5, s6, s7};
    foreach (vals[i]) applyStimulus(1'b1, vals[i], r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, int'($urandom_range(0, 65535)) - 32768, r);
  endtask

  initial begin
    I_reset_n = 1'b0;
    I_valid   = 1'b0;
    I_data    = '0;
    O_ready   = 1'b0;
    applyReset();

    $display("[TB] constant frame");
    sendFrame(100, 100, 100, 100, 100, 100, 100, 100, 1'b1);
    idle(3, 1'b1);

    $display("[TB] rounding");
    sendFrame(1, 1, 1, 1, 0, 0, 0, 0, 1'b1);
    sendFrame(-1, -1, -1, -1, -1, -1, -1, -1, 1'b1);
    sendFrame(-4, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    sendFrame(5, -3, 12, 0, -7, 2, 1, 3, 1'b1);
    idle(3, 1'b1);

    $display("[TB] extremes");
    sendFrame(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 1'b1);
    sendFrame(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 1'b1);
    idle(3, 1'b1);

    $display("[TB] gapped input");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 7, 1'b1);
      applyStimulus(1'b0, int'($urandom_range(0, 65535)) - 32768, 1'b1);
    end
    idle(3, 1'b1);

    $display("[TB] backpressure");
    for (int f = 0; f < 5; f++)
      sendFrame(f * 3 + 1, f * 3 + 1, f * 3 + 1, f * 3 + 1,
                f * 3 + 1, f * 3 + 1, f * 3 + 1, f * 3 + 1, 1'b0);
    idle(2, 1'b0);
    checkOutput("bp_level_full", int'(O_level), 4);
    checkOutput("bp_overrun_set", int'(O_overrun), 1);
    idle(2, 1'b1);
    sendFrame(20, 20, 20, 20, 20, 20, 20, 21, 1'b1);
    idle(6, 1'b1);
    checkOutput("bp_drained", int'(O_valid), 0);
    checkOutput("bp_overrun_sticky", int'(O_overrun), 1);

    $display("[TB] full FIFO with simultaneous pop");
    applyReset();
    for (int f = 0; f < 4; f++)
      sendFrame(f - 9, f - 9, f - 9, f - 9, f - 9, f - 9, f - 9, f - 9, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 50, 1'b0);
    applyStimulus(1'b1, 50, 1'b1);
    idle(6, 1'b1);
    checkOutput("pushpop_no_overrun", int'(O_overrun), 0);

    $display("[TB] reset mid-frame");
    sendFrame(55, 55, 55, 55, 55, 55, 55, 55, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1000, 1'b0);
    applyReset();
    sendFrame(10, 10, 10, 10, 10, 10, 10, 10, 1'b1);
    idle(3, 1'b1);
    checkOutput("post_reset_result", lastHead, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
